// File: rtl/dp_alu_pkg.sv
// rtl/dp_alu_pkg.sv - shared opcode and FSM state constants for dp_alu_exec
package dp_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MUL_RUN = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add multiplier, one multiplier bit per cycle
// start_i loads operands; done_o is high during the final step, when product_o is the full result.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [WIDTH-1:0] acc_d;

  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = run_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dp_alu_exec.sv
// rtl/dp_alu_exec.sv - handshaked ALU execute stage with optional sequential MUL
// Define DP_ALU_MUL_EN to build the multiplier; otherwise opcode 011 returns 0 with latency 1.
module dp_alu_exec
  import dp_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] SignExtended,
  input  logic             ALUSrc,
  input  logic [OPW-1:0]   operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluOut,
  output logic             ALUZeroFlag,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] alu_res;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [OPW-1:0]   op);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OPW'(OP_AND): r = a & b;
      OPW'(OP_OR):  r = a | b;
      OPW'(OP_ADD): r = a + b;
      OPW'(OP_SUB): r = a - b;
      OPW'(OP_SLT): r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OPW'(OP_NOR): r = ~(a | b);
      default:      r = '0;
    endcase
    return r;
  endfunction

  assign opb       = ALUSrc ? SignExtended : ReadData2;
  assign alu_res   = alu_fn(ReadData1, opb, operation);
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign aluOut    = res_q;
  assign ALUZeroFlag = zero_q;

`ifdef DP_ALU_MUL_EN
  logic [WIDTH-1:0] a_q, b_q;
  logic             start_q;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign is_mul = (operation == OPW'(OP_MUL));

  // Operands are latched at acceptance and the multiplier is started from the
  // latched copies, so later input changes cannot disturb the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= in_valid && in_ready && is_mul;
      if (in_valid && in_ready) begin
        a_q <= ReadData1;
        b_q <= opb;
      end
    end
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef DP_ALU_MUL_EN
          if (is_mul) begin
            state_d = S_MUL_RUN;
          end else begin
            state_d = S_DONE;
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
          end
`else
          state_d = S_DONE;
          res_d   = alu_res;
          zero_d  = (alu_res == '0);
`endif
        end
      end
      S_MUL_RUN: begin
`ifdef DP_ALU_MUL_EN
        if (mul_done) begin
          state_d = S_DONE;
          res_d   = mul_product;
          zero_d  = (mul_product == '0);
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_dp_alu_exec.sv
// tb/tb_dp_alu_exec.sv - directed self-checking bench for dp_alu_exec
module tb_dp_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ReadData1, ReadData2, SignExtended;
  logic        ALUSrc;
  logic [2:0]  operation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluOut;
  logic        ALUZeroFlag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dp_alu_exec #(.WIDTH(32), .OPW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .SignExtended (SignExtended),
    .ALUSrc       (ALUSrc),
    .operation    (operation),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .aluOut       (aluOut),
    .ALUZeroFlag  (ALUZeroFlag),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] se, input logic src);
    @(negedge clk);
    operation    = op;
    ReadData1    = a;
    ReadData2    = r2;
    SignExtended = se;
    ALUSrc       = src;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid     = 1'b0;
    ReadData1    = 32'hDEAD_BEEF;
    ReadData2    = 32'h1234_5678;
    SignExtended = 32'hCAFE_F00D;
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] r2, input logic [31:0] se, input logic src,
                         input logic [31:0] exp);
    issue(op, a, r2, se, src);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_res"}, {32'd0, aluOut}, {32'd0, exp});
    check({tag, "_zero"}, {63'd0, ALUZeroFlag}, {63'd0, (exp == 32'd0)});
    consume(tag);
  endtask

  initial begin
    int n;
    logic saw_ready;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ReadData1 = '0; ReadData2 = '0; SignExtended = '0; ALUSrc = 1'b0; operation = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_aluout", {32'd0, aluOut}, 64'd0);
    check("rst_zero", {63'd0, ALUZeroFlag}, 64'd0);
    rst = 1'b0;

    run_vec("add", 3'b010, 32'd5, 32'd7, 32'd99, 1'b0, 32'd12);
    run_vec("sub_imm", 3'b110, 32'd9, 32'd3, 32'd9, 1'b1, 32'd0);
    run_vec("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1);
    run_vec("slt_pos", 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0);
    run_vec("and", 3'b000, 32'hF0F0_1234, 32'hFF00_FF00, 32'd0, 1'b0, 32'hF000_1200);
    run_vec("nor", 3'b100, 32'hF0F0_F0F0, 32'd0, 32'h0F0F_0000, 1'b1, 32'h0000_0F0F);
    run_vec("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 32'd1);
    run_vec("sub_wrap", 3'b110, 32'd0, 32'd1, 32'd0, 1'b0, 32'hFFFF_FFFF);
    run_vec("bad_op", 3'b101, 32'd6, 32'd6, 32'd0, 1'b0, 32'd0);

`ifdef DP_ALU_MUL_EN
    issue(3'b011, 32'h0001_0000, 32'h0001_0001, 32'd0, 1'b0);
    n = 1;
    saw_ready = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    check("mul_latency", 64'(n), 64'd33);
    check("mul_no_ready", {63'd0, saw_ready}, 64'd0);
    check("mul_res", {32'd0, aluOut}, 64'h0001_0000);
    consume("mul");
`else
    run_vec("mul_off", 3'b011, 32'd3, 32'd4, 32'd0, 1'b0, 32'd0);
`endif

    // Result held in DONE while the consumer stalls; new operands must be ignored.
    issue(3'b001, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b0);
    in_valid  = 1'b1;
    ReadData1 = 32'h1111_1111;
    operation = 3'b010;
    for (int i = 0; i < 5; i++) begin
      check("hold_res", {32'd0, aluOut}, 64'hFF);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_idle", {63'd0, in_ready}, 64'd1);
    check("rel_valid", {63'd0, out_valid}, 64'd0);
    check("rel_res", {32'd0, aluOut}, 64'hFF);

    // Back-to-back consumption with out_ready already high.
    out_ready = 1'b1;
    issue(3'b010, 32'd40, 32'd2, 32'd0, 1'b0);
    check("fast_valid", {63'd0, out_valid}, 64'd1);
    check("fast_res", {32'd0, aluOut}, 64'd42);
    @(negedge clk);
    check("fast_gone", {63'd0, out_valid}, 64'd0);
    check("fast_idle", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;

`ifdef DP_ALU_MUL_EN
    issue(3'b011, 32'd5, 32'd7, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
`else
    issue(3'b010, 32'd2, 32'd3, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
`endif
    rst = 1'b1;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_res", {32'd0, aluOut}, 64'd0);
    check("midrst_zero", {63'd0, ALUZeroFlag}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) saw_ready = 1'b1;
    end
    check("midrst_discard", {63'd0, saw_ready}, 64'd0);
    run_vec("post_rst_add", 3'b010, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_alu_exec.md
DP_ALU_EXEC -- requirements
Module: dp_alu_exec

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal values 8..64).
REQ-002 The module SHALL have parameter OPW, default 3, giving the operation code width.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit, which marks the operand set as valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit, which signals that the unit can accept an operand set.
REQ-007 The module SHALL have port ReadData1, input, WIDTH bits, carrying operand A.
REQ-008 The module SHALL have port ReadData2, input, WIDTH bits, carrying operand B when ALUSrc is 0.
REQ-009 The module SHALL have port SignExtended, input, WIDTH bits, carrying operand B when ALUSrc is 1.
REQ-010 The module SHALL have port ALUSrc, input, 1 bit, which selects operand B.
REQ-011 The module SHALL have port operation, input, OPW bits, giving the operation code.
REQ-012 The module SHALL have port out_valid, output, 1 bit, which marks the result as valid.
REQ-013 The module SHALL have port out_ready, input, 1 bit, which signals that the consumer accepts the result.
REQ-014 The module SHALL have port aluOut, output, WIDTH bits, carrying the registered result.
REQ-015 The module SHALL have port ALUZeroFlag, output, 1 bit, which is 1 when aluOut is all zeros.
REQ-016 The module SHALL have port busy, output, 1 bit, which is high whenever the FSM is not in IDLE.

Function
REQ-017 The operation codes SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed, result 1 or 0), 011 MUL (low WIDTH bits of the product), 100 NOR; any other code SHALL yield result 0.
REQ-018 The FSM SHALL have states IDLE, MUL_RUN and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 An operand set SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-021 On acceptance, the unit SHALL capture A, the selected B and operation into internal registers.
REQ-022 On acceptance of a non-MUL operation, the FSM SHALL go to DONE, so that out_valid is 1 in the cycle after acceptance (latency 1).
REQ-023 On acceptance of a MUL operation, the FSM SHALL go to MUL_RUN and perform a shift-add of one multiplier bit per cycle for exactly WIDTH cycles, then go to DONE (latency WIDTH+1).
REQ-024 In DONE: out_valid SHALL be 1, and aluOut and ALUZeroFlag SHALL be held stable until out_ready is 1; the FSM SHALL then return to IDLE on that edge.
REQ-025 Outside DONE, out_valid SHALL be 0, and aluOut and ALUZeroFlag SHALL hold their last values.
REQ-026 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-027 Input changes while not in IDLE SHALL have no effect on the result in progress.
REQ-028 If out_ready is already 1 when DONE is entered, the result SHALL be consumed after one cycle of out_valid.

Reset
REQ-029 While rst is 1 (at any time, including mid-MUL): the FSM SHALL be in IDLE; in_ready SHALL be 1; out_valid, busy and ALUZeroFlag SHALL be 0; aluOut and the internal registers SHALL be 0.
REQ-030 An operation in progress when rst asserts SHALL be discarded without producing any output.

Configuration
REQ-031 When macro DP_ALU_MUL_EN is defined, MUL SHALL behave as specified in REQ-023.
REQ-032 When DP_ALU_MUL_EN is undefined: the multiplier logic SHALL be absent, the MUL_RUN state SHALL be unreachable, and code 011 SHALL yield result 0 with latency 1.

Structure
REQ-033 The operation code constants and the FSM state encoding SHALL reside in shared package dp_alu_pkg.
REQ-034 The shift-add multiplier SHALL be a separate sub-module, seq_multiplier (WIDTH parameter; start/done handshake), instantiated only under DP_ALU_MUL_EN.

Verification
REQ-035 Bench scenario (WIDTH=32): ADD with A=5, ReadData2=7, ALUSrc=0 -> aluOut=12 and ALUZeroFlag=0, one cycle after acceptance.
REQ-036 Bench scenario: SUB with A=9, SignExtended=9, ALUSrc=1 -> aluOut=0 and ALUZeroFlag=1; SLT with A=-1, B=1 -> aluOut=1.
REQ-037 Bench scenario (DP_ALU_MUL_EN defined): MUL 0x10000 × 0x10001 -> aluOut=0x10000 with out_valid after 33 cycles; in_ready=0 throughout.
REQ-038 Bench scenario: hold out_ready=0 for 5 cycles in DONE -> aluOut stable, out_valid stays 1, no new acceptance; then out_ready=1 -> IDLE on the next edge.
REQ-039 Bench scenario: assert rst at cycle 10 of a MUL -> out_valid=0 and in_ready=1 immediately; the next ADD 1+1 gives 2.
REQ-040 Bench scenario (DP_ALU_MUL_EN undefined): MUL 3×4 -> aluOut=0 with latency 1.
